// File: rtl/test_ram_arbiter_pkg.sv
// Shared definitions for the TestRam arbiter: FSM states, port encoding, defaults.
package test_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    TRA_ST_IDLE    = 2'd0,
    TRA_ST_ACCESS  = 2'd1,
    TRA_ST_RECOVER = 2'd2
  } tra_state_e;

  localparam logic TRA_PORT_A = 1'b0;
  localparam logic TRA_PORT_B = 1'b1;

  localparam int TRA_TIMEOUT_CYCLES_DEFAULT = 15;
  localparam int TRA_TIMEOUT_CNT_WIDTH      = 8;

endpackage

// File: rtl/test_ram_arbiter_rr_pick.sv
// Two-input round-robin picker. On a tie the port that was not granted last wins.
module test_ram_rr_pick
  import test_ram_arbiter_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_sel
);

  // Pick the single requester, or alternate against last_grant when both ask
  always_comb begin
    grant_valid = a_req | b_req;
    grant_sel   = TRA_PORT_A;
    if (a_req && b_req) begin
      grant_sel = ~last_grant;
    end else if (b_req) begin
      grant_sel = TRA_PORT_B;
    end
  end

endmodule

// File: rtl/test_ram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the TestRam block-RAM model.
// One transaction at a time, a one-cycle ack per access, a recovery cycle after
// each access so a stale data_ready is never taken as the next completion.
module test_ram_arbiter
  import test_ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = TRA_TIMEOUT_CYCLES_DEFAULT
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_req_rdwr,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic                  ram_data_ready,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam logic [TRA_TIMEOUT_CNT_WIDTH-1:0] TimeoutLimit =
    TRA_TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES);

  tra_state_e                       state_q;
  logic                             lastGrant_q;
  logic                             grantSel_q;
  logic [TRA_TIMEOUT_CNT_WIDTH-1:0] timeoutCnt_q;
  logic [TRA_TIMEOUT_CNT_WIDTH-1:0] timeoutCnt_d;
  logic                             aAck_q;
  logic                             bAck_q;
  logic [DATA_WIDTH-1:0]            aRdata_q;
  logic [DATA_WIDTH-1:0]            bRdata_q;
  logic                             ramReq_q;
  logic                             ramWe_q;
  logic [ADDR_WIDTH-1:0]            ramAddr_q;
  logic [DATA_WIDTH-1:0]            ramDataIn_q;
  logic                             busy_q;
  logic                             timeoutErr_q;

  logic                             pickValid;
  logic                             pickSel;
  logic                             selWe;
  logic [ADDR_WIDTH-1:0]            selAddr;
  logic [DATA_WIDTH-1:0]            selWdata;
  logic                             accessDone;

  test_ram_rr_pick u_pick (
    .a_req       (a_req),
    .b_req       (b_req),
    .last_grant  (lastGrant_q),
    .grant_valid (pickValid),
    .grant_sel   (pickSel)
  );

  assign selWe        = (pickSel == TRA_PORT_B) ? b_we    : a_we;
  assign selAddr      = (pickSel == TRA_PORT_B) ? b_addr  : a_addr;
  assign selWdata     = (pickSel == TRA_PORT_B) ? b_wdata : a_wdata;
  assign timeoutCnt_d = timeoutCnt_q + 1'b1;
  assign accessDone   = ram_data_ready || (timeoutCnt_d == TimeoutLimit);

  // Arbitration, RAM sequencing, timeout abort and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= TRA_ST_IDLE;
      lastGrant_q  <= TRA_PORT_B;
      grantSel_q   <= TRA_PORT_A;
      timeoutCnt_q <= '0;
      aAck_q       <= 1'b0;
      bAck_q       <= 1'b0;
      aRdata_q     <= '0;
      bRdata_q     <= '0;
      ramReq_q     <= 1'b0;
      ramWe_q      <= 1'b0;
      ramAddr_q    <= '0;
      ramDataIn_q  <= '0;
      busy_q       <= 1'b0;
      timeoutErr_q <= 1'b0;
    end else begin
      aAck_q <= 1'b0;
      bAck_q <= 1'b0;
      case (state_q)
        TRA_ST_IDLE: begin
          // TestRam has no reset, so a ready still high from before blocks arbitration
          if (!ram_data_ready && pickValid) begin
            grantSel_q   <= pickSel;
            ramWe_q      <= selWe;
            ramAddr_q    <= selAddr;
            ramDataIn_q  <= selWdata;
            ramReq_q     <= 1'b1;
            timeoutCnt_q <= '0;
            busy_q       <= 1'b1;
            state_q      <= TRA_ST_ACCESS;
          end
        end
        TRA_ST_ACCESS: begin
          if (accessDone) begin
            if (grantSel_q == TRA_PORT_B) begin
              bAck_q <= 1'b1;
              if (ram_data_ready && !ramWe_q) bRdata_q <= ram_data_out;
            end else begin
              aAck_q <= 1'b1;
              if (ram_data_ready && !ramWe_q) aRdata_q <= ram_data_out;
            end
            if (!ram_data_ready) timeoutErr_q <= 1'b1;
            ramReq_q    <= 1'b0;
            ramWe_q     <= 1'b0;
            lastGrant_q <= grantSel_q;
            state_q     <= TRA_ST_RECOVER;
          end else begin
            timeoutCnt_q <= timeoutCnt_d;
          end
        end
        TRA_ST_RECOVER: begin
          busy_q  <= 1'b0;
          state_q <= TRA_ST_IDLE;
        end
        default: begin
          ramReq_q <= 1'b0;
          ramWe_q  <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= TRA_ST_IDLE;
        end
      endcase
    end
  end

  assign a_ack        = aAck_q;
  assign b_ack        = bAck_q;
  assign a_rdata      = aRdata_q;
  assign b_rdata      = bRdata_q;
  assign ram_req_rdwr = ramReq_q;
  assign ram_we       = ramWe_q;
  assign ram_addr     = ramAddr_q;
  assign ram_data_in  = ramDataIn_q;
  assign busy         = busy_q;
  assign timeout_err  = timeoutErr_q;

endmodule
